// File: rtl/ram_sp_ctrl_pkg.sv
// Shared types and sizing helpers for the single-port SRAM port controller.
package ram_sp_ctrl_pkg;

   // Controller phase: sweep the array after reset, then serve requests.
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ctrl_state_t;

   // The response FIFO holds every read that can be in the SRAM pipeline plus
   // two extra entries, so that a ready consumer sees one word per cycle.
   function automatic int fifo_depth(input int lat);
      return lat + 2;
   endfunction

endpackage

// File: rtl/ram_sp_rsp_fifo.sv
// Small synchronous FIFO that holds SRAM read data until the consumer takes it.
module ram_sp_rsp_fifo #(
   parameter int DATA  = 72,
   parameter int DEPTH = 3,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_push,
   input  logic [DATA-1:0] i_wdata,
   input  logic            i_pop,
   output logic            o_valid,
   output logic [DATA-1:0] o_rdata,
   output logic [CW-1:0]   o_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA-1:0] r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            w_pop;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A pop on an empty FIFO is ignored.
   assign w_pop = i_pop & (r_count != '0);

   // Storage array; data is not reset, the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // Pointers and occupancy; simultaneous push and pop keep the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         unique case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Head word is forced to zero while empty so the output is clean after reset.
   assign o_valid = (r_count != '0);
   assign o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

   // The upstream credit scheme must never push into a full FIFO.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(i_push && !w_pop && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/ram_sp_port_ctrl.sv
// Initiator-side port controller: valid/ready requests in, legal single-port
// SRAM cycles out, read data returned in order through a response FIFO.
module ram_sp_port_ctrl
   import ram_sp_ctrl_pkg::*;
#(
   parameter int              DATA     = 72,
   parameter int              ADDR     = 9,
   parameter int              DEPTH    = 2 ** ADDR,
   parameter int              LAT      = 1,
   parameter int              INIT_EN  = 1,
   parameter logic [DATA-1:0] INIT_VAL = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [ADDR-1:0] req_addr,
   input  logic [DATA-1:0] req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DATA-1:0] rsp_rdata,
   output logic            init_done,
   output logic            ram_chip_en,
   output logic            ram_write_en,
   output logic [ADDR-1:0] ram_addr,
   output logic [DATA-1:0] ram_write_data,
   input  logic [DATA-1:0] ram_read_data
);

   localparam int FIFO_DEPTH = fifo_depth(LAT);
   localparam int CW         = $clog2(FIFO_DEPTH + 1);

   ctrl_state_t     r_state;
   ctrl_state_t     w_state_nxt;
   logic [ADDR-1:0] r_init_cnt;
   logic [LAT-1:0]  r_inflight;
   logic [CW-1:0]   w_fifo_cnt;
   logic [CW-1:0]   w_inflight_cnt;
   logic            w_credit;
   logic            w_rd_acc;
   logic            w_capture;
   logic            w_pop;

   function automatic logic [CW-1:0] count_ones(input logic [LAT-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < LAT; i++) n = n + CW'(v[i]);
      return n;
   endfunction

   // A read may issue only if its data is guaranteed a FIFO slot on arrival.
   // A pop in the same cycle is deliberately not counted as a free slot.
   assign w_inflight_cnt = count_ones(r_inflight);
   assign w_credit = ({1'b0, w_inflight_cnt} + {1'b0, w_fifo_cnt}) < (CW + 1)'(FIFO_DEPTH);

   // Phase register and init address counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
         r_init_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 1'b1;
      end
   end

   // Next phase, request handshake and the combinational SRAM port.
   always_comb begin
      w_state_nxt    = r_state;
      req_ready      = 1'b0;
      ram_chip_en    = 1'b0;
      ram_write_en   = 1'b0;
      ram_addr       = req_addr;
      ram_write_data = req_wdata;
      w_rd_acc       = 1'b0;
      unique case (r_state)
         ST_INIT: begin
            ram_chip_en    = 1'b1;
            ram_write_en   = 1'b1;
            ram_addr       = r_init_cnt;
            ram_write_data = INIT_VAL;
            if (r_init_cnt == ADDR'(DEPTH - 1)) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // Writes are posted and always flow; rst masks the handshake while held.
            req_ready    = (req_we | w_credit) & ~rst;
            ram_chip_en  = req_valid & req_ready;
            ram_write_en = req_we & ram_chip_en;
            w_rd_acc     = ram_chip_en & ~req_we;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   assign init_done = (r_state == ST_RUN);

   // In-flight read tracker: one bit per SRAM pipeline stage.
   generate
      if (LAT == 1) begin : g_lat1
         // Single stage: data arrives on the edge after the read is issued.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) r_inflight <= '0;
            else     r_inflight <= w_rd_acc;
         end
      end else begin : g_latn
         // Multi-stage: shift the issue marker along with the SRAM pipeline.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) r_inflight <= '0;
            else     r_inflight <= {r_inflight[LAT-2:0], w_rd_acc};
         end
      end
   endgenerate

   assign w_capture = r_inflight[LAT-1];
   assign w_pop     = rsp_valid & rsp_ready;

   ram_sp_rsp_fifo #(
      .DATA  (DATA),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_capture),
      .i_wdata (ram_read_data),
      .i_pop   (w_pop),
      .o_valid (rsp_valid),
      .o_rdata (rsp_rdata),
      .o_count (w_fifo_cnt)
   );

endmodule

// File: tb/tb_ram_sp_port_ctrl.sv
// Directed bench: a LAT=2 controller with init sweep and a LAT=1 controller
// without, each driving a behavioural single-port SRAM.
module tb_ram_sp_port_ctrl;

   localparam logic [71:0] IV = 72'h11_2233_4455_6677_8899;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] pat(input int a);
      return {8'(a) ^ 8'h3C, 32'hCAFE_0000 | 32'(a), 32'(a * 7)};
   endfunction

   // ---------------- DUT with LAT=2, init sweep enabled ----------------
   logic        rst2, v2, rdy2, we2, rv2, rr2, done2, ce2, wen2;
   logic [8:0]  addr2, ra2;
   logic [71:0] wd2, rd2, rwd2, rrd2, s2;
   logic [71:0] mem2 [512];

   ram_sp_port_ctrl #(
      .DATA(72), .ADDR(9), .DEPTH(512), .LAT(2), .INIT_EN(1), .INIT_VAL(IV)
   ) u_dut2 (
      .clk(clk), .rst(rst2), .req_valid(v2), .req_ready(rdy2), .req_we(we2),
      .req_addr(addr2), .req_wdata(wd2), .rsp_valid(rv2), .rsp_ready(rr2),
      .rsp_rdata(rd2), .init_done(done2), .ram_chip_en(ce2), .ram_write_en(wen2),
      .ram_addr(ra2), .ram_write_data(rwd2), .ram_read_data(rrd2)
   );

   // Two-cycle-latency SRAM model
   always @(posedge clk) begin
      if (ce2 && wen2)  mem2[ra2] <= rwd2;
      if (ce2 && !wen2) s2 <= mem2[ra2];
      rrd2 <= s2;
   end

   // ---------------- DUT with LAT=1, no init sweep ----------------
   logic        rst1, v1, rdy1, we1, rv1, rr1, done1, ce1, wen1;
   logic [3:0]  addr1, ra1;
   logic [71:0] wd1, rd1, rwd1, rrd1;
   logic [71:0] mem1 [16];

   ram_sp_port_ctrl #(
      .DATA(72), .ADDR(4), .DEPTH(16), .LAT(1), .INIT_EN(0), .INIT_VAL(72'h0)
   ) u_dut1 (
      .clk(clk), .rst(rst1), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
      .req_addr(addr1), .req_wdata(wd1), .rsp_valid(rv1), .rsp_ready(rr1),
      .rsp_rdata(rd1), .init_done(done1), .ram_chip_en(ce1), .ram_write_en(wen1),
      .ram_addr(ra1), .ram_write_data(rwd1), .ram_read_data(rrd1)
   );

   // One-cycle-latency SRAM model
   always @(posedge clk) begin
      if (ce1 && wen1)  mem1[ra1] <= rwd1;
      if (ce1 && !wen1) rrd1 <= mem1[ra1];
   end

   // Init sweep monitor on DUT2: sequential addresses carrying INIT_VAL.
   int init_idx = 0;
   int init_bad = 0;
   int rsp_seen = 0;
   always @(posedge clk) begin
      if (!rst2 && ce2 && wen2 && !done2) begin
         if (ra2 !== init_idx[8:0] || rwd2 !== IV) init_bad++;
         init_idx++;
      end
      if (rv2) rsp_seen++;
   end

   initial begin
      int acc;
      rst1 = 1'b1; rst2 = 1'b1;
      v1 = 1'b0; we1 = 1'b0; addr1 = '0; wd1 = '0; rr1 = 1'b1;
      v2 = 1'b0; we2 = 1'b0; addr2 = '0; wd2 = '0; rr2 = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst2_req_ready", rdy2, 0);
      chk("rst2_rsp_valid", rv2, 0);
      chk("rst2_rsp_rdata", rd2, 0);
      chk("rst2_init_done", done2, 0);
      chk("rst2_chip_en", ce2, 1);
      chk("rst2_write_en", wen2, 1);
      chk("rst2_addr", ra2, 0);
      chk("rst1_init_done", done1, 1);
      chk("rst1_req_ready", rdy1, 0);
      chk("rst1_rsp_valid", rv1, 0);
      chk("rst1_chip_en", ce1, 0);
      chk("rst1_write_en", wen1, 0);

      // Init sweep: exactly 512 cycles
      init_idx = 0; init_bad = 0;
      rst1 = 1'b0; rst2 = 1'b0;
      for (int k = 1; k <= 512; k++) begin
         @(negedge clk);
         if (k == 511) chk("init_done_early", done2, 0);
      end
      chk("init_done", done2, 1);
      chk("init_words", 72'(init_idx), 512);
      chk("init_seq", 72'(init_bad), 0);
      chk("init_first_ready", rdy2, 1);

      // Read an untouched address: INIT_VAL, first valid at edge t+2
      v2 = 1'b1; we2 = 1'b0; addr2 = 9'd100;
      #1 chk("rdiv_ready", rdy2, 1);
      @(negedge clk); v2 = 1'b0;
      chk("rdiv_t0", rv2, 0);
      @(negedge clk); chk("rdiv_t1", rv2, 0);
      @(negedge clk); chk("rdiv_valid", rv2, 1); chk("rdiv_data", rd2, IV);
      @(negedge clk); chk("rdiv_popped", rv2, 0);

      // LAT=1: write A5 to addr 3, read it back next cycle
      v1 = 1'b1; we1 = 1'b1; addr1 = 4'd3; wd1 = 72'hA5;
      #1 chk("w1_ready", rdy1, 1); chk("w1_ce", ce1, 1); chk("w1_we", wen1, 1);
      @(negedge clk); we1 = 1'b0;
      #1 chk("r1_ready", rdy1, 1); chk("r1_we", wen1, 0); chk("r1_addr", ra1, 3);
      @(negedge clk); v1 = 1'b0; we1 = 1'b1;
      #1 chk("idle1_we", wen1, 0); chk("idle1_ce", ce1, 0); chk("r1_early", rv1, 0);
      @(negedge clk); chk("r1_valid", rv1, 1); chk("r1_data", rd1, 72'hA5);
      @(negedge clk); chk("r1_popped", rv1, 0);
      we1 = 1'b0;

      // LAT=2: fill 16 words, then 16 back-to-back reads
      for (int i = 0; i < 16; i++) begin
         v2 = 1'b1; we2 = 1'b1; addr2 = 9'(10 + i); wd2 = pat(10 + i);
         #1 chk($sformatf("wr16_ready%0d", i), rdy2, 1);
         @(negedge clk);
      end
      v2 = 1'b0; we2 = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (c >= 3 && c < 19) begin
            chk($sformatf("b2b_valid%0d", c - 3), rv2, 1);
            chk($sformatf("b2b_data%0d", c - 3), rd2, pat(10 + c - 3));
         end else begin
            chk($sformatf("b2b_idle%0d", c), rv2, 0);
         end
         if (c < 16) begin
            v2 = 1'b1; we2 = 1'b0; addr2 = 9'(10 + c);
            #1 chk($sformatf("b2b_ready%0d", c), rdy2, 1);
         end else begin
            v2 = 1'b0;
         end
         @(negedge clk);
      end

      // Back-pressure: only FIFO_DEPTH reads accepted, writes still flow
      rr2 = 1'b0; acc = 0;
      for (int i = 0; i < 8; i++) begin
         v2 = 1'b1; we2 = 1'b0; addr2 = 9'(10 + acc);
         #1 if (rdy2) acc++;
         @(negedge clk);
      end
      chk("bp_accepted", 72'(acc), 4);
      #1 chk("bp_rd_blocked", rdy2, 0);
      chk("bp_hold_valid", rv2, 1);
      chk("bp_hold_data", rd2, pat(10));
      we2 = 1'b1; addr2 = 9'd40; wd2 = pat(40);
      #1 chk("bp_wr_ready", rdy2, 1); chk("bp_wr_ce", ce2, 1);
      @(negedge clk); v2 = 1'b0; we2 = 1'b0;
      chk("bp_hold_data2", rd2, pat(10));
      rr2 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain_valid%0d", k), rv2, 1);
         chk($sformatf("drain_data%0d", k), rd2, pat(10 + k));
         @(negedge clk);
      end
      chk("drain_empty", rv2, 0);

      // Write that went in under back-pressure is readable
      v2 = 1'b1; we2 = 1'b0; addr2 = 9'd40;
      @(negedge clk); v2 = 1'b0;
      @(negedge clk);
      @(negedge clk); chk("rd40_valid", rv2, 1); chk("rd40_data", rd2, pat(40));
      @(negedge clk);

      // Reset with two reads in flight
      v2 = 1'b1; we2 = 1'b0; addr2 = 9'd10;
      @(negedge clk); addr2 = 9'd11;
      @(negedge clk); v2 = 1'b0;
      rst2 = 1'b1; init_idx = 0; init_bad = 0; rsp_seen = 0;
      #1 chk("mid_rst_valid", rv2, 0);
      chk("mid_rst_rdata", rd2, 0);
      chk("mid_rst_addr", ra2, 0);
      chk("mid_rst_ce", ce2, 1);
      chk("mid_rst_ready", rdy2, 0);
      chk("mid_rst_done", done2, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("mid_rst_hold%0d", k), rv2, 0);
      end
      rst2 = 1'b0;
      repeat (512) @(negedge clk);
      chk("reinit_done", done2, 1);
      chk("reinit_words", 72'(init_idx), 512);
      chk("reinit_seq", 72'(init_bad), 0);
      chk("reinit_no_rsp", 72'(rsp_seen), 0);

      // Array cleared again by the restarted sweep
      v2 = 1'b1; we2 = 1'b0; addr2 = 9'd10;
      @(negedge clk); v2 = 1'b0;
      @(negedge clk);
      @(negedge clk); chk("reinit_rd_valid", rv2, 1); chk("reinit_rd_data", rd2, IV);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
